// File: rtl/srff_pkg.sv
// Shared SR-flag command encodings and the flag update rule.
package srff_pkg;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

    // Next flag value; the illegal code leaves the flag untouched.
    function automatic logic sr_apply(input logic cur, input logic [1:0] code);
        case (code)
            SR_SET:   return 1'b1;
            SR_RESET: return 1'b0;
            default:  return cur;
        endcase
    endfunction

endpackage

// File: rtl/srff_bank_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any     = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt[gnt_idx] = any;
    end

endmodule

// File: rtl/srff_bank_arbiter.sv
// Round-robin shared access to a bank of SR flags; illegal or out-of-range
// commands are accepted but absorbed and flagged on err.
module srff_bank_arbiter
    import srff_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NFLAGS = 8,
    parameter int unsigned AW     = $clog2(NFLAGS),
    parameter int unsigned CW     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*2-1:0]       req_sr,
    output logic [NFLAGS-1:0]       flags,
    output logic                    sr_strobe,
    output logic [AW-1:0]           sr_sel,
    output logic [1:0]              sr_code,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    err,
    output logic [CW-1:0]           accept_cnt
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_any;
    logic              accept;
    logic [AW-1:0]     acc_addr;
    logic [1:0]        acc_sr;

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              sr_strobe_q, sr_strobe_d;
    logic [AW-1:0]     sr_sel_q, sr_sel_d;
    logic [1:0]        sr_code_q, sr_code_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic              err_q, err_d;
    logic [CW-1:0]     accept_cnt_q, accept_cnt_d;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Grants are suppressed during reset so nothing is accepted.
    assign req_ready = rst ? '0 : gnt;
    assign accept    = gnt_any && !rst;
    assign acc_addr  = req_addr[32'(gnt_idx) * AW +: AW];
    assign acc_sr    = req_sr[32'(gnt_idx) * 2 +: 2];

    always_comb begin
        flags_d      = flags_q;
        rr_ptr_d     = rr_ptr_q;
        sr_strobe_d  = 1'b0;
        sr_sel_d     = sr_sel_q;
        sr_code_d    = sr_code_q;
        grant_id_d   = grant_id_q;
        err_d        = 1'b0;
        accept_cnt_d = accept_cnt_q;
        if (accept) begin
            sr_strobe_d  = 1'b1;
            sr_sel_d     = acc_addr;
            grant_id_d   = gnt_idx;
            accept_cnt_d = accept_cnt_q + CW'(1);
            rr_ptr_d     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            if ((32'(acc_addr) >= NFLAGS) || (acc_sr == SR_ILLEGAL)) begin
                err_d     = 1'b1;
                sr_code_d = SR_HOLD;
            end else begin
                sr_code_d         = acc_sr;
                flags_d[acc_addr] = sr_apply(flags_q[acc_addr], acc_sr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= '0;
            rr_ptr_q     <= '0;
            sr_strobe_q  <= 1'b0;
            sr_sel_q     <= '0;
            sr_code_q    <= SR_HOLD;
            grant_id_q   <= '0;
            err_q        <= 1'b0;
            accept_cnt_q <= '0;
        end else begin
            flags_q      <= flags_d;
            rr_ptr_q     <= rr_ptr_d;
            sr_strobe_q  <= sr_strobe_d;
            sr_sel_q     <= sr_sel_d;
            sr_code_q    <= sr_code_d;
            grant_id_q   <= grant_id_d;
            err_q        <= err_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign flags      = flags_q;
    assign sr_strobe  = sr_strobe_q;
    assign sr_sel     = sr_sel_q;
    assign sr_code    = sr_code_q;
    assign grant_id   = grant_id_q;
    assign err        = err_q;
    assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Directed + random bench for srff_bank_arbiter with a scoreboard queue of
// expected post-edge outputs, built from an independent reference model.
module tb_srff_bank_arbiter;

    localparam int NREQ = 4;
    localparam int NFL  = 8;
    localparam int AW   = 3;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [11:0]     req_addr;
    logic [7:0]      req_sr;
    logic [7:0]      flags;
    logic            sr_strobe;
    logic [2:0]      sr_sel;
    logic [1:0]      sr_code;
    logic [1:0]      grant_id;
    logic            err;
    logic [3:0]      accept_cnt;

    srff_bank_arbiter #(.NREQ(NREQ), .NFLAGS(NFL), .AW(AW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_sr     (req_sr),
        .flags      (flags),
        .sr_strobe  (sr_strobe),
        .sr_sel     (sr_sel),
        .sr_code    (sr_code),
        .grant_id   (grant_id),
        .err        (err),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] flags;
        logic       strobe;
        logic [2:0] sel;
        logic [1:0] code;
        logic [1:0] gid;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   m_ptr;
    int   last_g;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check the grant, push the expected outcome, then compare.
    task automatic cycle();
        logic [3:0] eg;
        exp_t       e, got;
        int         g;
        logic [2:0] a;
        logic [1:0] s;
        @(negedge clk);
        eg = '0;
        g  = -1;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));
        e = m;
        e.strobe = 1'b0;
        e.err    = 1'b0;
        if (rst) begin
            e     = '0;
            m_ptr = 0;
        end else if (g >= 0) begin
            a        = req_addr[g*AW +: AW];
            s        = req_sr[g*2 +: 2];
            e.strobe = 1'b1;
            e.sel    = a;
            e.gid    = 2'(g);
            e.cnt    = m.cnt + 4'd1;
            m_ptr    = (g + 1) % NREQ;
            if (s == 2'b11) begin
                e.err  = 1'b1;
                e.code = 2'b00;
            end else begin
                e.code = s;
                if (s == 2'b10) e.flags[a] = 1'b1;
                if (s == 2'b01) e.flags[a] = 1'b0;
            end
        end
        last_g = g;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("flags",      32'(flags),      32'(got.flags));
        chk("sr_strobe",  32'(sr_strobe),  32'(got.strobe));
        chk("sr_sel",     32'(sr_sel),     32'(got.sel));
        chk("sr_code",    32'(sr_code),    32'(got.code));
        chk("grant_id",   32'(grant_id),   32'(got.gid));
        chk("err",        32'(err),        32'(got.err));
        chk("accept_cnt", 32'(accept_cnt), 32'(got.cnt));
        m = got;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [1:0] s);
        req_addr[i*AW +: AW] = a;
        req_sr[i*2 +: 2]     = s;
    endtask

    initial begin
        m      = '0;
        m_ptr  = 0;
        last_g = -1;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = '0;
        req_sr    = '0;

        // Reset with everyone requesting: nothing may be granted.
        cycle();
        cycle();
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_cnt",   32'(accept_cnt), 32'h0);

        // Single set of flag 3 by requester 0.
        rst = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 3'd3, 2'b10);
        cycle();
        chk("set3_flags", 32'(flags), 32'h08);
        chk("set3_code",  32'(sr_code), 32'h2);
        req_valid = 4'b0000;
        cycle();
        chk("idle_strobe", 32'(sr_strobe), 32'h0);

        // Reset again so the pointer starts at 0 for the full sweep.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 2'b10);
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            cycle();
            chk("sweep_gid", 32'(grant_id), 32'(i));
            if (last_g >= 0) req_valid[last_g] = 1'b0;
        end
        chk("sweep_flags", 32'(flags), 32'h0F);
        chk("sweep_cnt",   32'(accept_cnt), 32'h4);

        // Illegal code against a set flag is absorbed and flagged.
        req_valid = 4'b0001;
        set_req(0, 3'd5, 2'b10);
        cycle();
        req_valid = 4'b0100;
        set_req(2, 3'd5, 2'b11);
        cycle();
        chk("ill_err",   32'(err), 32'h1);
        chk("ill_code",  32'(sr_code), 32'h0);
        chk("ill_flag5", 32'(flags[5]), 32'h1);
        req_valid = 4'b0000;
        cycle();
        chk("ill_err_pulse", 32'(err), 32'h0);

        // Set then reset the same flag back-to-back; later command wins.
        req_valid = 4'b0110;
        set_req(1, 3'd6, 2'b10);
        set_req(2, 3'd6, 2'b01);
        cycle();
        chk("f6_set", 32'(flags[6]), 32'h1);
        req_valid[last_g] = 1'b0;
        cycle();
        chk("f6_clr", 32'(flags[6]), 32'h0);
        req_valid = 4'b1111;
        cycle();
        chk("ptr3_gid", 32'(grant_id), 32'h3);

        // Reset pulse right after a req3 accept.
        req_valid = 4'b1000;
        set_req(3, 3'd7, 2'b10);
        cycle();
        rst = 1'b1;
        req_valid = 4'b1111;
        cycle();
        chk("rst2_flags", 32'(flags), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 2'b00);
        for (int i = 0; i < 16; i++) cycle();
        chk("wrap_cnt", 32'(accept_cnt), 32'h0);

        // Random traffic over all codes and addresses.
        for (int i = 0; i < 60; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int r = 0; r < NREQ; r++) set_req(r, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/srff_bank_arbiter.md
Name: srff_bank_arbiter

Overview:
- Shares one bank of NFLAGS set/reset flags between NREQ requesters.
- Each cycle the block arbitrates requests round-robin and applies at most one set, reset or hold command to one flag.
- It never drives the illegal S=R=1 combination onto a flag; that request is absorbed and reported as an error.
- It sits between control requesters and the SR-flag status bank, and exports both the flag vector and a registered per-command strobe.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAGS, 8, number of SR flags in the bank
- AW, $clog2(NFLAGS), flag address width
- CW, 16, width of the accepted-command counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, rr_ptr and rst
- req_addr  in  NREQ*AW  packed flag index, requester i at [i*AW +: AW]
- req_sr  in  NREQ*2  packed {s,r} code, requester i at [i*2 +: 2]
- flags  out  NFLAGS  registered flag states
- sr_strobe  out  1  registered pulse, one cycle after each accepted command
- sr_sel  out  AW  registered address of the last accepted command
- sr_code  out  2  registered {s,r} actually applied; 11 is never output
- grant_id  out  $clog2(NREQ)  registered index of the last accepted requester
- err  out  1  registered pulse: last accepted command was illegal (11) or addressed a flag >= NFLAGS
- accept_cnt  out  CW  count of accepted commands, wraps modulo 2^CW

Behaviour:
- Reset, while rst=1 at a rising edge:
  - flags=0, rr_ptr=0, sr_strobe=0, sr_sel=0, sr_code=00, grant_id=0, err=0, accept_cnt=0.
  - req_ready is all-zero while rst=1, so no command is accepted.
  - Reset asserted mid-stream discards any pending request; requesters hold valid and retry.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NREQ; the first with req_valid=1 gets req_ready=1.
  - At most one req_ready bit is high at any time.
- Handshake:
  - A command is accepted on a rising edge when req_valid[i] & req_ready[i].
  - A requester must hold valid, addr and sr stable until accepted. Dropping valid early is legal; that request is simply lost.
- Pointer: after an accept by requester g, rr_ptr <= (g+1) mod NREQ. With no accept, rr_ptr holds.
- Command decode, applied on the accepting edge (latency 1: new flags visible the cycle after accept):
  - 00: hold; flag unchanged; sr_code=00.
  - 01: flags[addr] <= 0; sr_code=01.
  - 10: flags[addr] <= 1; sr_code=10.
  - 11: flag unchanged; sr_code=00; err=1.
  - addr >= NFLAGS: no flag change; sr_code=00; err=1.
- On every accept:
  - sr_strobe=1, sr_sel=addr, grant_id=g.
  - accept_cnt increments, wrapping from 2^CW-1 to 0.
  - This applies to illegal commands and holds too.
- Idle cycles: sr_strobe=0, err=0; sr_sel, sr_code and grant_id hold their last values.
- Back-to-back accepts on consecutive cycles are allowed; there are no bubbles.
- Two accepted commands to the same flag on consecutive cycles: the later one wins.

Decomposition:
- Shared package srff_pkg:
  - SR code constants SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11.
  - Function sr_apply(cur, code) returning the next flag value (11 returns cur).
- One sub-module rr_arbiter (params N; ports req, ptr, gnt one-hot, gnt_idx, any), purely combinational. The top holds rr_ptr, the flag bank and the output registers.

Test Plan:
- rst=1 for 2 cycles with all req_valid=1 -> req_ready=0000, flags=00000000, accept_cnt=0; after rst drops, req_ready=0001.
- Req0 valid addr=3 sr=10 -> accepted the same cycle; next cycle flags=00001000, sr_strobe=1, sr_sel=3, sr_code=10, grant_id=0, err=0.
- All four requesters valid continuously, each setting a distinct addr 0..3 -> grants in order 0,1,2,3 on consecutive cycles; flags=00001111 after 4 accepts; accept_cnt=4.
- Req2 sr=11 addr=5 with flag 5 previously 1 -> accepted; flags[5] stays 1; err=1 for exactly one cycle; sr_code=00.
- Req1 sets addr 6, then req2 resets addr 6 on the next cycle -> flags[6] is 1 for one cycle, then 0; rr_ptr=3 afterwards.
- rst pulsed the cycle after req3 is accepted -> flags cleared; rr_ptr=0; req0 is granted first after release; with CW=4 forced, 16 accepts wrap accept_cnt to 0.
